// File: rtl/grid_cfg_pkg.sv
// grid_cfg_pkg: shared configuration-chain constants and the chain-length helper
package grid_cfg_pkg;
  localparam int CFG_BITS_PER_PAD = 2;
  localparam int CFG_OE_OFS = 0;
  localparam int CFG_INV_OFS = 1;
  function automatic int chain_len(input int num_pads);
    return num_pads * CFG_BITS_PER_PAD;
  endfunction
endpackage

// File: rtl/ccff_shadow_chain.sv
// ccff_shadow_chain: W-bit config shift chain with a length-checked commit into a shadow copy
module ccff_shadow_chain #(
  parameter int W = 16,
  parameter int CNT_W = $clog2(W + 2)
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         head_i,
  input  logic         shift_en_i,
  input  logic         commit_i,
  output logic         tail_o,
  output logic [W-1:0] shadow_o,
  output logic         done_o,
  output logic         err_o
);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(W + 1);
  logic [W-1:0] chain_q, chain_d, shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic done_q, done_d, err_q, err_d;
  logic commit_ok;
  assign commit_ok = commit_i & ~shift_en_i & (cnt_q == CNT_FULL);
  // Shifting always wins; a commit only lands when idle and exactly W bits arrived
  always_comb begin
    chain_d = shift_en_i ? {chain_q[W-2:0], head_i} : chain_q;
    cnt_d = shift_en_i ? ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1) : (commit_i ? '0 : cnt_q);
    shadow_d = commit_ok ? chain_q : shadow_q;
    done_d = done_q | commit_ok;
    err_d = commit_i ? ~commit_ok : err_q;
  end
  // State registers, cleared asynchronously so pads float immediately on reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      chain_q <= '0;
      shadow_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      chain_q <= chain_d;
      shadow_q <= shadow_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign tail_o = chain_q[W-1];
  assign shadow_o = shadow_q;
  assign done_o = done_q;
  assign err_o = err_q;
endmodule

// File: rtl/grid_io_cfg_bank.sv
// grid_io_cfg_bank: IO grid tile with per-pad OE/INV config behind a shadowed config chain
module grid_io_cfg_bank
  import grid_cfg_pkg::*;
#(
  parameter int NUM_PADS = 8
) (
  input  logic                prog_clk,
  input  logic                pReset_n,
  input  logic                ccff_head,
  input  logic                ccff_shift_en,
  input  logic                ccff_commit,
  output logic                ccff_tail,
  output logic                cfg_done,
  output logic                cfg_err,
  input  logic [NUM_PADS-1:0] fabric_outpad,
  output logic [NUM_PADS-1:0] fabric_inpad,
  input  logic [NUM_PADS-1:0] pad_in,
  output logic [NUM_PADS-1:0] pad_out,
  output logic [NUM_PADS-1:0] pad_oe
);
  localparam int CHAIN_LEN = chain_len(NUM_PADS);
  localparam int CNT_W = $clog2(CHAIN_LEN + 2);
  logic [CHAIN_LEN-1:0] shadow;
  ccff_shadow_chain #(.W(CHAIN_LEN), .CNT_W(CNT_W)) u_chain (
    .clk_i(prog_clk),
    .rst_n_i(pReset_n),
    .head_i(ccff_head),
    .shift_en_i(ccff_shift_en),
    .commit_i(ccff_commit),
    .tail_o(ccff_tail),
    .shadow_o(shadow),
    .done_o(cfg_done),
    .err_o(cfg_err)
  );
  // Per-pad datapath; loopback to fabric is gated while the pad drives
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    assign pad_oe[p] = cfg_done & shadow[p*CFG_BITS_PER_PAD+CFG_OE_OFS];
    assign pad_out[p] = fabric_outpad[p] ^ shadow[p*CFG_BITS_PER_PAD+CFG_INV_OFS];
    assign fabric_inpad[p] = pad_oe[p] ? 1'b0 : pad_in[p];
  end
endmodule

// File: doc/grid_io_cfg_bank.md
Name: grid_io_cfg_bank

Overview:
- Parametrised next-generation IO grid tile with NUM_PADS IO subtiles on one configuration chain.
- Adds what the fixed 8-pad tile lacks:
  - per-pad direction (output-enable) and output-invert configuration bits;
  - a shadow/commit stage so pads never toggle while the chain is shifting;
  - a shift counter that checks chain length and flags misprogramming.
- Sits at the fabric edge between the routing channel (fabric side) and the chip pad ring (pad side).

Parameters:
- NUM_PADS, 8, number of IO subtiles in the tile (1..64).
- CHAIN_LEN, 2*NUM_PADS, derived localparam: configuration bits in the chain. Must not be overridden.
- CNT_W, $clog2(CHAIN_LEN+2), derived localparam: shift counter width.

Ports:
- prog_clk  input  1  configuration clock; the only clock.
- pReset_n  input  1  asynchronous, active-low reset.
- ccff_head  input  1  configuration chain serial input.
- ccff_shift_en  input  1  shift enable; chain advances one bit per prog_clk edge while high.
- ccff_commit  input  1  single-cycle strobe: copy chain to shadow config.
- ccff_tail  output  1  chain serial output, chain[CHAIN_LEN-1].
- cfg_done  output  1  shadow config valid; pads live.
- cfg_err  output  1  sticky commit-length / protocol error.
- fabric_outpad  input  NUM_PADS  fabric-to-pad data, one bit per subtile.
- fabric_inpad  output  NUM_PADS  pad-to-fabric data.
- pad_in  input  NUM_PADS  pad receiver value.
- pad_out  output  NUM_PADS  pad driver value.
- pad_oe  output  NUM_PADS  pad driver enable (1 = drive).

Behaviour:
- Chain bit map: chain[2p] = OE of pad p, chain[2p+1] = INV of pad p.
- Shift (ccff_shift_en=1): chain[0] <= ccff_head and chain[i] <= chain[i-1] on the prog_clk rising edge.
  - First bit shifted in lands in chain[CHAIN_LEN-1] (INV of pad NUM_PADS-1) after CHAIN_LEN shifts.
  - ccff_tail is a registered output: latency head->tail is CHAIN_LEN shifts.
- Shift counter: +1 per shift, saturating at CHAIN_LEN+1 so overshoot stays detectable.
- Commit (ccff_commit=1, ccff_shift_en=0):
  - If count==CHAIN_LEN: shadow <= chain, cfg_done <= 1, cfg_err <= 0, count <= 0.
  - Otherwise: shadow unchanged, cfg_err <= 1, count <= 0. cfg_done holds its value.
- Commit and shift in the same cycle: the shift is performed and the commit is rejected. Result: cfg_err <= 1, shadow unchanged, count = old+1 (saturating).
- Reconfiguration: shifting while cfg_done=1 is allowed. Pads keep the old shadow config until a valid commit.
- Combinational outputs:
  - pad_oe[p] = cfg_done & shadow_oe[p].
  - pad_out[p] = fabric_outpad[p] ^ shadow_inv[p].
  - fabric_inpad[p] = pad_oe[p] ? 0 : pad_in[p]. Loopback is gated while a pad is driving.
- Reset (pReset_n=0, asynchronous, effective without a clock edge):
  - chain, shadow and count = 0; cfg_done = 0; cfg_err = 0; ccff_tail = 0.
  - Hence pad_oe = 0 (all pads high-Z) and pad_out = fabric_outpad.
  - Reset mid-shift discards partial data; a full CHAIN_LEN reload is required after reset.
- Release of pReset_n is assumed synchronised upstream. The block adds no reset synchroniser.

Decomposition:
- Shared package grid_cfg_pkg holds:
  - CFG_BITS_PER_PAD = 2;
  - bit-offset constants CFG_OE_OFS = 0 and CFG_INV_OFS = 1;
  - a function for chain-length computation.
- One natural sub-module: ccff_shadow_chain.
  - Generic W-bit shift chain with commit shadow, length counter, done and err flags.
  - Reused later by CLB/switch-block config banks.
- The top level instantiates it with W = CHAIN_LEN and adds the per-pad combinational datapath through a generate loop.

Test Plan (NUM_PADS=8, CHAIN_LEN=16):
- Reset: assert pReset_n=0 with no clock. Required: pad_oe=8'h00, cfg_done=0, cfg_err=0, ccff_tail=0 immediately; pad_out equals fabric_outpad.
- Program and commit:
  - Shift 16 bits giving pad0 OE=1/INV=0 and pad1 OE=1/INV=1, all others 0, then one commit cycle.
  - Next cycle: cfg_done=1, pad_oe=8'h03.
  - With fabric_outpad=8'hFF: pad_out=8'hFD.
- Chain pass-through: after programming, shift 16 more zeros. Required: ccff_tail reproduces the original 16-bit stream in order; pad_oe stays 8'h03 throughout.
- Length errors:
  - 15 shifts then commit: cfg_err=1, pad_oe unchanged.
  - 20 shifts then commit: cfg_err=1.
  - Correct 16-shift commit afterwards: cfg_err=0.
- Protocol error: assert ccff_shift_en and ccff_commit together. Required: cfg_err=1, shadow unchanged, one bit shifted.
- Input gating and async reset:
  - With pad_oe=8'h03 and pad_in=8'hA5: fabric_inpad=8'hA4.
  - Assert pReset_n=0 mid-shift (after 8 bits): pad_oe=8'h00 and fabric_inpad=8'hA5 without a clock edge.
